// File: rtl/uart_param.sv
// Parameterised UART: independent TX and RX engines sharing one clock.
// RX oversamples a 2-flop synchronised line and samples every bit mid-period.
module uart_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3,
    RX_STOP = 3'd4, RX_WAIT_IDLE = 3'd5
  } rx_state_t;

  tx_state_t              tx_state_r, tx_state_s;
  logic [CNT_W-1:0]       tx_cnt_r, tx_cnt_s;
  logic [3:0]             tx_idx_r, tx_idx_s;
  logic [DATA_BITS-1:0]   tx_shift_r, tx_shift_s;
  logic                   tx_par_r, tx_par_s;
  logic                   tx_r, tx_line_s, tx_ready_r;
  logic                   tx_bit_end_s;

  assign tx_bit_end_s = (tx_cnt_r == BIT_LAST);
  assign tx           = tx_r;
  assign tx_ready     = tx_ready_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= '0;
      tx_idx_r   <= 4'd0;
      tx_shift_r <= '0;
      tx_par_r   <= 1'b0;
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_idx_r   <= tx_idx_s;
      tx_shift_r <= tx_shift_s;
      tx_par_r   <= tx_par_s;
      tx_r       <= tx_line_s;
      tx_ready_r <= (tx_state_s == TX_IDLE);
    end
  end

  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r + CNT_ONE;
    tx_idx_s   = tx_idx_r;
    tx_shift_s = tx_shift_r;
    tx_par_s   = tx_par_r;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_s = '0;
        tx_idx_s = 4'd0;
        if (tx_valid && tx_ready_r) begin
          tx_state_s = TX_START;
          tx_shift_s = tx_data;
          tx_par_s   = parity_of(tx_data);
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_bit_end_s) begin
          tx_state_s = TX_DATA;
          tx_cnt_s   = '0;
        end else begin
          tx_state_s = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_bit_end_s) begin
          tx_cnt_s   = '0;
          tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
          if (tx_idx_r == DATA_LAST) begin
            tx_idx_s   = 4'd0;
            tx_state_s = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          end else begin
            tx_idx_s = tx_idx_r + 4'd1;
          end
        end else begin
          tx_state_s = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tx_bit_end_s) begin
          tx_state_s = TX_STOP;
          tx_cnt_s   = '0;
        end else begin
          tx_state_s = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tx_bit_end_s) begin
          tx_cnt_s = '0;
          if (tx_idx_r == STOP_LAST) begin
            tx_idx_s   = 4'd0;
            tx_state_s = TX_IDLE;
          end else begin
            tx_idx_s = tx_idx_r + 4'd1;
          end
        end else begin
          tx_state_s = TX_STOP;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = '0;
        tx_idx_s   = 4'd0;
      end
    endcase
  end

  // Line level is computed for the state being entered so tx changes on the same edge.
  always_comb begin
    case (tx_state_s)
      TX_IDLE:   tx_line_s = 1'b1;
      TX_START:  tx_line_s = 1'b0;
      TX_DATA:   tx_line_s = tx_shift_s[0];
      TX_PARITY: tx_line_s = tx_par_s;
      TX_STOP:   tx_line_s = 1'b1;
      default:   tx_line_s = 1'b1;
    endcase
  end

  logic                 sync_1_r, sync_2_r, rx_prev_r, rx_s;
  rx_state_t            rx_state_r, rx_state_s;
  logic [CNT_W-1:0]     rx_cnt_r, rx_cnt_s;
  logic [3:0]           rx_idx_r, rx_idx_s;
  logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
  logic                 rx_par_bit_r, rx_par_bit_s;
  logic                 rx_ferr_r, rx_ferr_s;
  logic                 rx_strobe_s;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, rx_perr_out_r, rx_ferr_out_r;
  logic                 rx_half_s, rx_full_s;

  assign rx_s          = sync_2_r;
  assign rx_half_s     = (rx_cnt_r == HALF_LAST);
  assign rx_full_s     = (rx_cnt_r == BIT_LAST);
  assign rx_data       = rx_data_r;
  assign rx_valid      = rx_valid_r;
  assign rx_parity_err = rx_perr_out_r;
  assign rx_frame_err  = rx_ferr_out_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1_r      <= 1'b1;
      sync_2_r      <= 1'b1;
      rx_prev_r     <= 1'b1;
      rx_state_r    <= RX_IDLE;
      rx_cnt_r      <= '0;
      rx_idx_r      <= 4'd0;
      rx_shift_r    <= '0;
      rx_par_bit_r  <= 1'b0;
      rx_ferr_r     <= 1'b0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      rx_perr_out_r <= 1'b0;
      rx_ferr_out_r <= 1'b0;
    end else begin
      sync_1_r     <= rx;
      sync_2_r     <= sync_1_r;
      rx_prev_r    <= rx_s;
      rx_state_r   <= rx_state_s;
      rx_cnt_r     <= rx_cnt_s;
      rx_idx_r     <= rx_idx_s;
      rx_shift_r   <= rx_shift_s;
      rx_par_bit_r <= rx_par_bit_s;
      rx_ferr_r    <= rx_ferr_s;
      rx_valid_r   <= rx_strobe_s;
      if (rx_strobe_s) begin
        rx_data_r     <= rx_shift_r;
        rx_perr_out_r <= (PARITY_EN != 0) && (rx_par_bit_r != parity_of(rx_shift_r));
        rx_ferr_out_r <= rx_ferr_s;
      end
    end
  end

  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r + CNT_ONE;
    rx_idx_s   = rx_idx_r;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = '0;
        rx_idx_s = 4'd0;
        if (rx_prev_r && !rx_s) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_half_s) begin
          rx_cnt_s   = '0;
          rx_state_s = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_full_s) begin
          rx_cnt_s = '0;
          if (rx_idx_r == DATA_LAST) begin
            rx_idx_s   = 4'd0;
            rx_state_s = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_s = rx_idx_r + 4'd1;
          end
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (rx_full_s) begin
          rx_cnt_s   = '0;
          rx_state_s = RX_STOP;
        end else begin
          rx_state_s = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (rx_full_s) begin
          rx_cnt_s = '0;
          if (rx_idx_r == STOP_LAST) begin
            rx_idx_s   = 4'd0;
            rx_state_s = (rx_ferr_r || !rx_s) ? RX_WAIT_IDLE : RX_IDLE;
          end else begin
            rx_idx_s = rx_idx_r + 4'd1;
          end
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      // A low line after a framing error is a break: hold off until it recovers.
      RX_WAIT_IDLE: begin
        rx_cnt_s = '0;
        if (rx_s) begin
          rx_state_s = RX_IDLE;
        end else begin
          rx_state_s = RX_WAIT_IDLE;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = '0;
        rx_idx_s   = 4'd0;
      end
    endcase
  end

  always_comb begin
    rx_shift_s   = rx_shift_r;
    rx_par_bit_s = rx_par_bit_r;
    rx_ferr_s    = rx_ferr_r;
    rx_strobe_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: rx_ferr_s = 1'b0;
      RX_DATA: begin
        if (rx_full_s) begin
          rx_shift_s = {rx_s, rx_shift_r[DATA_BITS-1:1]};
        end else begin
          rx_shift_s = rx_shift_r;
        end
      end
      RX_PARITY: begin
        if (rx_full_s) begin
          rx_par_bit_s = rx_s;
        end else begin
          rx_par_bit_s = rx_par_bit_r;
        end
      end
      RX_STOP: begin
        if (rx_full_s) begin
          rx_ferr_s   = rx_ferr_r | !rx_s;
          rx_strobe_s = (rx_idx_r == STOP_LAST);
        end else begin
          rx_ferr_s = rx_ferr_r;
        end
      end
      default: rx_strobe_s = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_param.sv
// Directed bench: default UART in tx->rx loopback or driven rx, plus a 7N2 instance in loopback.
module tb_uart_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_line;
  logic       rx_in, rx_drv, loop_sel;
  logic [7:0] rx_data;
  logic       rx_valid, perr, ferr;

  logic [6:0] tx7_data;
  logic       tx7_valid, tx7_ready, tx7_line;
  logic [6:0] rx7_data;
  logic       rx7_valid, perr7, ferr7;

  int n_cmp = 0;
  int n_bad = 0;
  int s8_cnt = 0;
  int s7_cnt = 0;

  always #5 clk = ~clk;

  assign rx_in = loop_sel ? tx_line : rx_drv;

  uart_param dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx_line), .rx(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(perr), .rx_frame_err(ferr)
  );

  uart_param #(.DATA_BITS(7), .CLKS_PER_BIT(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst(rst), .tx_data(tx7_data), .tx_valid(tx7_valid), .tx_ready(tx7_ready),
    .tx(tx7_line), .rx(tx7_line), .rx_data(rx7_data), .rx_valid(rx7_valid),
    .rx_parity_err(perr7), .rx_frame_err(ferr7)
  );

  always @(negedge clk) begin
    if (rx_valid) s8_cnt <= s8_cnt + 1;
    if (rx7_valid) s7_cnt <= s7_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready8();
    int w = 0;
    while (tx_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check_eq("tx_ready_wait", tx_ready, 1);
  endtask

  task automatic wait_strobe8(input int c0, input string tag);
    int w = 0;
    while (s8_cnt == c0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    check_eq(tag, (s8_cnt != c0), 1);
  endtask

  task automatic drive_rx(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f11;
    logic [9:0]  f10;
    logic [15:0] fr;
    logic [7:0]  lb [3];
    logic [6:0]  lb7 [3];
    int c0, bad, low, w;

    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_drv = 1'b1; loop_sel = 1'b1;
    tx7_data = 7'h00; tx7_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx_line, 1);
    check_eq("rst_tx_ready", tx_ready, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_err_flags", {perr, ferr}, 2'b00);
    check_eq("rst_tx7_ready", tx7_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", tx_ready, 1);
    check_eq("ready7_after_rst", tx7_ready, 1);

    // 0xA5: start, 1,0,1,0,0,1,0,1, even parity 0, stop
    f11 = {1'b1, 1'b0, 8'hA5, 1'b0};
    c0 = s8_cnt; bad = 0; low = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = 8'hFF;
      if (tx_line !== f11[k/16]) bad++;
      if (tx_ready === 1'b0) low++;
      if (k % 16 == 8) check_eq($sformatf("tx_a5_bit%0d", k / 16), tx_line, f11[k/16]);
      if (k == 100) tx_valid = 1'b1;
    end
    tx_valid = 1'b0;
    check_eq("tx_a5_bad_cycles", bad, 0);
    check_eq("tx_a5_ready_low", low, 176);
    @(negedge clk);
    check_eq("tx_a5_ready_back", tx_ready, 1);
    check_eq("tx_a5_idle_line", tx_line, 1);
    wait_strobe8(c0, "rx_a5_strobe");
    check_eq("rx_a5_data", rx_data, 8'hA5);
    check_eq("rx_a5_errs", {perr, ferr}, 2'b00);
    repeat (20) @(negedge clk);
    check_eq("rx_a5_one_strobe", s8_cnt - c0, 1);

    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      c0 = s8_cnt;
      wait_ready8();
      tx_data = lb[i]; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_strobe8(c0, $sformatf("loop_strobe_%0h", lb[i]));
      check_eq($sformatf("loop_data_%0h", lb[i]), rx_data, lb[i]);
      check_eq($sformatf("loop_errs_%0h", lb[i]), {perr, ferr}, 2'b00);
    end
    wait_ready8();
    repeat (20) @(negedge clk);

    // 0x01 has even parity 1; send 0 to force a parity error
    loop_sel = 1'b0;
    c0 = s8_cnt;
    fr = {5'b00000, 1'b1, 1'b0, 8'h01, 1'b0};
    drive_rx(fr, 11);
    rx_drv = 1'b1;
    wait_strobe8(c0, "par_strobe");
    check_eq("par_data", rx_data, 8'h01);
    check_eq("par_perr", perr, 1);
    check_eq("par_ferr", ferr, 0);
    repeat (32) @(negedge clk);

    // 0x55 with low stop bit, then a 40-bit-time break
    c0 = s8_cnt;
    fr = {5'b00000, 1'b0, 1'b0, 8'h55, 1'b0};
    drive_rx(fr, 11);
    rx_drv = 1'b0;
    repeat (640) @(negedge clk);
    check_eq("brk_strobes", s8_cnt - c0, 1);
    check_eq("brk_data", rx_data, 8'h55);
    check_eq("brk_ferr", ferr, 1);
    check_eq("brk_perr", perr, 0);
    rx_drv = 1'b1;
    repeat (48) @(negedge clk);
    check_eq("brk_no_more", s8_cnt - c0, 1);

    c0 = s8_cnt;
    fr = {5'b00000, 1'b1, 1'b1, 8'h01, 1'b0};
    drive_rx(fr, 11);
    wait_strobe8(c0, "recov_strobe");
    check_eq("recov_data", rx_data, 8'h01);
    check_eq("recov_errs", {perr, ferr}, 2'b00);
    repeat (32) @(negedge clk);

    c0 = s8_cnt;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("glitch_no_strobe", s8_cnt - c0, 0);

    // reset during data bit 3 (frame cycles 64..79) of a looped-back 0xA5
    loop_sel = 1'b1;
    c0 = s8_cnt;
    wait_ready8();
    tx_data = 8'hA5; tx_valid = 1'b1;
    for (int k = 0; k <= 70; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    check_eq("mid_bit3_low", tx_line, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tx_high", tx_line, 1);
    check_eq("mid_rst_ready_low", tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready_back", tx_ready, 1);
    repeat (300) @(negedge clk);
    check_eq("mid_rst_no_strobe", s8_cnt - c0, 0);

    // 7 data bits, no parity, 2 stop bits, 8 clocks/bit: 10-bit, 80-cycle frame
    lb7[0] = 7'h00; lb7[1] = 7'h7F; lb7[2] = 7'h3C;
    for (int i = 0; i < 3; i++) begin
      f10 = {2'b11, lb7[i], 1'b0};
      c0 = s7_cnt; bad = 0; low = 0; w = 0;
      while (tx7_ready !== 1'b1 && w < 1000) begin
        @(negedge clk);
        w++;
      end
      tx7_data = lb7[i]; tx7_valid = 1'b1;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        tx7_valid = 1'b0;
        if (tx7_line !== f10[k/8]) bad++;
        if (tx7_ready === 1'b0) low++;
      end
      @(negedge clk);
      check_eq($sformatf("t7_frame_%0h", lb7[i]), bad, 0);
      check_eq($sformatf("t7_ready_low_%0h", lb7[i]), low, 80);
      check_eq($sformatf("t7_ready_back_%0h", lb7[i]), tx7_ready, 1);
      w = 0;
      while (s7_cnt == c0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      check_eq($sformatf("t7_strobe_%0h", lb7[i]), s7_cnt - c0, 1);
      check_eq($sformatf("t7_data_%0h", lb7[i]), rx7_data, lb7[i]);
      check_eq($sformatf("t7_errs_%0h", lb7[i]), {perr7, ferr7}, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
